// File: rtl/wb_stream_reader_ctrl_pkg.sv
// rtl/wb_stream_reader_ctrl_pkg.sv - shared constants and FSM encoding for the stream reader controller
//
// Contents:
//   CTI_* / BTE_*      Wishbone registered-feedback cycle and burst type codes
//   state_t            controller FSM state encoding
//   burst_len_width()  width of a beat counter able to hold MAX_BURST_LEN

package wb_stream_reader_ctrl_pkg;

    localparam logic [2:0] CTI_CLASSIC   = 3'b000;
    localparam logic [2:0] CTI_INC_BURST = 3'b010;
    localparam logic [2:0] CTI_END       = 3'b111;

    localparam logic [1:0] BTE_LINEAR    = 2'b00;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_SPACE = 2'd1,
        BURST      = 2'd2,
        DONE       = 2'd3
    } state_t;

    // Beat counters must hold the value MAX_BURST_LEN itself, hence the +1.
    function automatic int burst_len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/wb_stream_burst_calc.sv
// rtl/wb_stream_burst_calc.sv - burst length clamp, beats-this-burst and FIFO space check
//
// Purely combinational; shared between the reader and writer controllers.
// Ports:
//   burst_size    in   requested words per burst (0 means 1)
//   blen          in   latched, already clamped burst length
//   remaining     in   words still to move in the current buffer
//   fifo_cnt      in   current FIFO fill level in words
//   blen_clamped  out  burst_size clamped to [1, MAX_BURST_LEN]
//   beats         out  min(blen, remaining)
//   space_ok      out  FIFO has room for the whole next burst

module wb_stream_burst_calc
    import wb_stream_reader_ctrl_pkg::*;
#(
    parameter int AW            = 32,
    parameter int FIFO_AW       = 0,
    parameter int MAX_BURST_LEN = 32,
    parameter int BLW           = burst_len_width(MAX_BURST_LEN)
) (
    input  logic [AW-1:0]    burst_size,
    input  logic [BLW-1:0]   blen,
    input  logic [AW-1:0]    remaining,
    input  logic [FIFO_AW:0] fifo_cnt,
    output logic [BLW-1:0]   blen_clamped,
    output logic [BLW-1:0]   beats,
    output logic             space_ok
);

    localparam logic [AW-1:0] MAX_LEN    = AW'(MAX_BURST_LEN);
    localparam logic [AW-1:0] FIFO_DEPTH = AW'(2 ** FIFO_AW);

    logic [AW-1:0] free;

    always_comb begin
        blen_clamped = burst_size[BLW-1:0];
        if (burst_size == '0) begin
            blen_clamped = BLW'(1);
        end else if (burst_size > MAX_LEN) begin
            blen_clamped = BLW'(MAX_BURST_LEN);
        end
    end

    // The final burst of a buffer may be shorter than blen.
    always_comb begin
        beats = blen;
        if (remaining < AW'(blen)) begin
            beats = remaining[BLW-1:0];
        end
    end

    // A burst is only started when every beat is guaranteed a FIFO slot,
    // so the bus never has to be throttled mid-burst.
    assign free     = FIFO_DEPTH - AW'(fifo_cnt);
    assign space_ok = (free >= AW'(beats));

endmodule

// File: rtl/wb_stream_reader_ctrl.sv
// rtl/wb_stream_reader_ctrl.sv - Wishbone burst-read master feeding the stream output FIFO
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wbm_*                     Wishbone master (read only, linear incrementing bursts)
//   fifo_d, fifo_wr           FIFO write port; fifo_wr follows ack in the same cycle
//   fifo_cnt                  FIFO fill level, used to hold off bursts that would overflow
//   enable                    start pulse, honoured only when idle
//   start_adr, buf_size,
//   burst_size                transfer setup, latched on start
//   busy, tx_cnt              status back to the config block

module wb_stream_reader_ctrl
    import wb_stream_reader_ctrl_pkg::*;
#(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 0,
    parameter int MAX_BURST_LEN = 32
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW-1:0]     wbm_dat_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    output logic [WB_DW-1:0]     fifo_d,
    output logic                 fifo_wr,
    input  logic [FIFO_AW:0]     fifo_cnt,
    input  logic                 enable,
    input  logic [WB_AW-1:0]     start_adr,
    input  logic [WB_AW-1:0]     buf_size,
    input  logic [WB_AW-1:0]     burst_size,
    output logic                 busy,
    output logic [WB_DW-1:0]     tx_cnt
);

    localparam int               BLW      = burst_len_width(MAX_BURST_LEN);
    localparam logic [WB_AW-1:0] ADR_STEP = WB_AW'(WB_DW / 8);

    state_t           state;
    logic [WB_AW-1:0] adr_q;
    logic [WB_AW-1:0] remaining_q;
    logic [BLW-1:0]   blen_q;
    logic [BLW-1:0]   beat_cnt_q;
    logic             cyc_q;
    logic             stb_q;
    logic             busy_q;
    logic [WB_DW-1:0] tx_cnt_q;

    logic [BLW-1:0]   blen_next;
    logic [BLW-1:0]   beats;
    logic             space_ok;
    logic             beat_ack;
    logic             beat_err;
    logic             unused_adr_bits;

    // Word-aligned addressing: the byte-lane bits of start_adr carry no meaning.
    assign unused_adr_bits = ^start_adr[1:0];

    wb_stream_burst_calc #(
        .AW            (WB_AW),
        .FIFO_AW       (FIFO_AW),
        .MAX_BURST_LEN (MAX_BURST_LEN),
        .BLW           (BLW)
    ) u_burst_calc (
        .burst_size   (burst_size),
        .blen         (blen_q),
        .remaining    (remaining_q),
        .fifo_cnt     (fifo_cnt),
        .blen_clamped (blen_next),
        .beats        (beats),
        .space_ok     (space_ok)
    );

    // An error on a beat wins over a simultaneous ack: that word is discarded.
    assign beat_err = stb_q & wbm_err_i;
    assign beat_ack = stb_q & wbm_ack_i & ~wbm_err_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            adr_q       <= '0;
            remaining_q <= '0;
            blen_q      <= BLW'(1);
            beat_cnt_q  <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            busy_q      <= 1'b0;
            tx_cnt_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        adr_q       <= {start_adr[WB_AW-1:2], 2'b00};
                        remaining_q <= buf_size;
                        blen_q      <= blen_next;
                        tx_cnt_q    <= '0;
                        busy_q      <= 1'b1;
                        // An empty buffer still produces one busy cycle so the
                        // config block sees a falling edge and raises its irq.
                        state       <= (buf_size == '0) ? DONE : WAIT_SPACE;
                    end
                end

                WAIT_SPACE: begin
                    if (space_ok) begin
                        cyc_q      <= 1'b1;
                        stb_q      <= 1'b1;
                        beat_cnt_q <= beats;
                        state      <= BURST;
                    end
                end

                BURST: begin
                    if (beat_err) begin
                        cyc_q <= 1'b0;
                        stb_q <= 1'b0;
                        state <= DONE;
                    end else if (beat_ack) begin
                        adr_q       <= adr_q + ADR_STEP;
                        tx_cnt_q    <= tx_cnt_q + WB_DW'(1);
                        remaining_q <= remaining_q - WB_AW'(1);
                        beat_cnt_q  <= beat_cnt_q - BLW'(1);
                        if (beat_cnt_q == BLW'(1)) begin
                            cyc_q <= 1'b0;
                            stb_q <= 1'b0;
                            state <= (remaining_q == WB_AW'(1)) ? DONE : WAIT_SPACE;
                        end
                    end
                end

                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = '0;
    assign wbm_sel_o = '1;
    assign wbm_we_o  = 1'b0;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_bte_o = BTE_LINEAR;

    // Classic outside a burst; end-of-burst on the last beat, including
    // single-beat bursts.
    assign wbm_cti_o = !stb_q                   ? CTI_CLASSIC :
                       (beat_cnt_q == BLW'(1))  ? CTI_END     : CTI_INC_BURST;

    assign fifo_d  = wbm_dat_i;
    assign fifo_wr = beat_ack;
    assign busy    = busy_q;
    assign tx_cnt  = tx_cnt_q;

endmodule

// File: tb/tb_wb_stream_reader_ctrl.sv
// tb/tb_wb_stream_reader_ctrl.sv - directed self-checking bench for wb_stream_reader_ctrl

module tb_wb_stream_reader_ctrl;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic [31:0] fifo_d;
    logic        fifo_wr;
    logic [3:0]  fifo_cnt = 4'd0;
    logic        enable = 1'b0;
    logic [31:0] start_adr = 32'd0;
    logic [31:0] buf_size = 32'd0;
    logic [31:0] burst_size = 32'd0;
    logic        busy;
    logic [31:0] tx_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] wr_d[$];
    logic [2:0]  wr_cti[$];
    logic [31:0] burst_adr[$];
    int          busy_cycles = 0;
    int          falls = 0;
    logic        busy_prev = 1'b0;
    logic        cyc_prev = 1'b0;

    logic ack_en = 1'b1;
    logic err_en = 1'b0;
    logic stall_mode = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    wb_stream_reader_ctrl #(
        .WB_AW(32), .WB_DW(32), .FIFO_AW(3), .MAX_BURST_LEN(8)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .fifo_d(fifo_d), .fifo_wr(fifo_wr), .fifo_cnt(fifo_cnt),
        .enable(enable), .start_adr(start_adr), .buf_size(buf_size),
        .burst_size(burst_size), .busy(busy), .tx_cnt(tx_cnt)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Memory slave: zero-wait unless stall_mode inserts a wait state every other cycle.
    assign wbm_ack_i = wbm_cyc_o & wbm_stb_o & ack_en & ~err_en;
    assign wbm_err_i = wbm_cyc_o & wbm_stb_o & err_en;
    assign wbm_dat_i = mem_word(wbm_adr_o);

    always @(posedge wb_clk_i) begin
        #1;
        ack_en = stall_mode ? ~ack_en : 1'b1;
    end

    always @(negedge wb_clk_i) begin
        if (fifo_wr === 1'b1) begin
            wr_d.push_back(fifo_d);
            wr_cti.push_back(wbm_cti_o);
        end
        if (wbm_cyc_o === 1'b1 && !cyc_prev) burst_adr.push_back(wbm_adr_o);
        if (busy === 1'b1) busy_cycles++;
        if (busy_prev && busy === 1'b0) falls++;
        busy_prev = (busy === 1'b1);
        cyc_prev  = (wbm_cyc_o === 1'b1);
    end

    task automatic step();
        @(negedge wb_clk_i);
        #1;
    endtask

    task automatic start_xfer(input logic [31:0] sa, input logic [31:0] bs, input logic [31:0] bu);
        start_adr  = sa;
        buf_size   = bs;
        burst_size = bu;
        enable     = 1'b1;
        step();
        enable     = 1'b0;
    endtask

    task automatic wait_done(input int fb);
        int k = 0;
        while (falls == fb && k < 400) begin
            step();
            k++;
        end
        if (falls == fb) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: busy never fell within %0d cycles", k);
        end
        step();
        step();
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        repeat (3) step();
        n_cmp++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin n_bad++; $display("FAIL reset_cyc_stb: got %b%b want 00", wbm_cyc_o, wbm_stb_o); end
        n_cmp++; if (fifo_wr !== 1'b0) begin n_bad++; $display("FAIL reset_fifo_wr: got %b want 0", fifo_wr); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (tx_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_tx_cnt: got %0d want 0", tx_cnt); end
        n_cmp++; if (wbm_adr_o !== 32'd0) begin n_bad++; $display("FAIL reset_adr: got %h want 0", wbm_adr_o); end
        n_cmp++; if (wbm_cti_o !== 3'b000) begin n_bad++; $display("FAIL reset_cti: got %b want 000", wbm_cti_o); end
        n_cmp++; if (wbm_we_o !== 1'b0 || wbm_sel_o !== 4'hF || wbm_bte_o !== 2'b00 || wbm_dat_o !== 32'd0) begin
            n_bad++; $display("FAIL reset_tied: we=%b sel=%h bte=%b dat=%h want 0 f 00 0", wbm_we_o, wbm_sel_o, wbm_bte_o, wbm_dat_o);
        end
        wb_rst_i = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int wb = wr_d.size(); int bb = burst_adr.size(); int fb = falls;
        logic [2:0] exp_cti;
        start_xfer(32'h1000, 32'd8, 32'd4);
        wait_done(fb);
        n_cmp++; if (wr_d.size() - wb != 8) begin n_bad++; $display("FAIL basic_count: got %0d want 8", wr_d.size() - wb); end
        for (int i = 0; i < 8; i++) if (wb + i < wr_d.size()) begin
            exp_cti = (i % 4 == 3) ? 3'b111 : 3'b010;
            n_cmp++; if (wr_d[wb+i] !== mem_word(32'h1000 + 32'(4*i))) begin n_bad++; $display("FAIL basic_data[%0d]: got %h want %h", i, wr_d[wb+i], mem_word(32'h1000 + 32'(4*i))); end
            n_cmp++; if (wr_cti[wb+i] !== exp_cti) begin n_bad++; $display("FAIL basic_cti[%0d]: got %b want %b", i, wr_cti[wb+i], exp_cti); end
        end
        n_cmp++; if (burst_adr.size() - bb != 2) begin n_bad++; $display("FAIL basic_bursts: got %0d want 2", burst_adr.size() - bb); end
        else begin
            n_cmp++; if (burst_adr[bb] !== 32'h1000 || burst_adr[bb+1] !== 32'h1010) begin n_bad++; $display("FAIL basic_burst_adr: got %h %h want 1000 1010", burst_adr[bb], burst_adr[bb+1]); end
        end
        n_cmp++; if (tx_cnt !== 32'd8) begin n_bad++; $display("FAIL basic_tx_cnt: got %0d want 8", tx_cnt); end
        n_cmp++; if (falls - fb != 1) begin n_bad++; $display("FAIL basic_busy_falls: got %0d want 1", falls - fb); end
    endtask

    task automatic test_short_final();
        int wb = wr_d.size(); int bb = burst_adr.size(); int fb = falls;
        logic [2:0] exp_cti;
        start_xfer(32'h1000, 32'd10, 32'd4);
        wait_done(fb);
        n_cmp++; if (wr_d.size() - wb != 10) begin n_bad++; $display("FAIL short_count: got %0d want 10", wr_d.size() - wb); end
        for (int i = 0; i < 10; i++) if (wb + i < wr_d.size()) begin
            exp_cti = (i % 4 == 3 || i == 9) ? 3'b111 : 3'b010;
            n_cmp++; if (wr_cti[wb+i] !== exp_cti) begin n_bad++; $display("FAIL short_cti[%0d]: got %b want %b", i, wr_cti[wb+i], exp_cti); end
        end
        n_cmp++; if (burst_adr.size() - bb != 3) begin n_bad++; $display("FAIL short_bursts: got %0d want 3", burst_adr.size() - bb); end
        else begin
            n_cmp++; if (burst_adr[bb+2] !== 32'h1020) begin n_bad++; $display("FAIL short_last_burst_adr: got %h want 1020", burst_adr[bb+2]); end
        end
        n_cmp++; if (wbm_adr_o !== 32'h1028) begin n_bad++; $display("FAIL short_final_adr: got %h want 1028", wbm_adr_o); end
        n_cmp++; if (tx_cnt !== 32'd10) begin n_bad++; $display("FAIL short_tx_cnt: got %0d want 10", tx_cnt); end
    endtask

    task automatic test_clamp();
        int wb = wr_d.size(); int bb = burst_adr.size(); int fb = falls;
        start_xfer(32'h0, 32'd10, 32'd9);
        wait_done(fb);
        n_cmp++; if (burst_adr.size() - bb != 2) begin n_bad++; $display("FAIL clamp_bursts: got %0d want 2", burst_adr.size() - bb); end
        else begin
            n_cmp++; if (burst_adr[bb+1] !== 32'h20) begin n_bad++; $display("FAIL clamp_burst2_adr: got %h want 20", burst_adr[bb+1]); end
        end
        if (wr_d.size() - wb == 10) begin
            n_cmp++; if (wr_cti[wb+6] !== 3'b010 || wr_cti[wb+7] !== 3'b111 || wr_cti[wb+9] !== 3'b111) begin
                n_bad++; $display("FAIL clamp_cti: got %b %b %b want 010 111 111", wr_cti[wb+6], wr_cti[wb+7], wr_cti[wb+9]);
            end
        end else begin
            n_cmp++; n_bad++; $display("FAIL clamp_count: got %0d want 10", wr_d.size() - wb);
        end
    endtask

    task automatic test_backpressure();
        int wb = wr_d.size(); int bb = burst_adr.size(); int fb = falls;
        fifo_cnt = 4'd6;
        start_xfer(32'h4000, 32'd4, 32'd4);
        repeat (10) step();
        n_cmp++; if (burst_adr.size() - bb != 0) begin n_bad++; $display("FAIL bp_stall_cnt6: got %0d bursts want 0", burst_adr.size() - bb); end
        fifo_cnt = 4'd5;
        repeat (5) step();
        n_cmp++; if (burst_adr.size() - bb != 0 || wbm_cyc_o !== 1'b0) begin n_bad++; $display("FAIL bp_stall_cnt5: got %0d bursts cyc=%b want 0 0", burst_adr.size() - bb, wbm_cyc_o); end
        fifo_cnt = 4'd4;
        wait_done(fb);
        fifo_cnt = 4'd0;
        n_cmp++; if (burst_adr.size() - bb != 1) begin n_bad++; $display("FAIL bp_bursts: got %0d want 1", burst_adr.size() - bb); end
        n_cmp++; if (wr_d.size() - wb != 4) begin n_bad++; $display("FAIL bp_count: got %0d want 4", wr_d.size() - wb); end
        n_cmp++; if (tx_cnt !== 32'd4) begin n_bad++; $display("FAIL bp_tx_cnt: got %0d want 4", tx_cnt); end
    endtask

    task automatic test_bus_error();
        int wb = wr_d.size(); int fb = falls; int k = 0;
        start_xfer(32'h6000, 32'd8, 32'd4);
        while (wbm_cyc_o !== 1'b1 && k < 20) begin step(); k++; end
        if (wbm_cyc_o !== 1'b1) begin
            n_cmp++; n_bad++; $display("FAIL err_no_cyc: got cyc=%b want 1", wbm_cyc_o);
        end else begin
            step();
            @(posedge wb_clk_i);
            #1;
            err_en = 1'b1;
            step();
            step();
            err_en = 1'b0;
            n_cmp++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin n_bad++; $display("FAIL err_cyc_drop: got cyc=%b stb=%b want 0 0", wbm_cyc_o, wbm_stb_o); end
            wait_done(fb);
            n_cmp++; if (wr_d.size() - wb != 2) begin n_bad++; $display("FAIL err_count: got %0d want 2", wr_d.size() - wb); end
            else begin
                n_cmp++; if (wr_d[wb+1] !== mem_word(32'h6004)) begin n_bad++; $display("FAIL err_data: got %h want %h", wr_d[wb+1], mem_word(32'h6004)); end
            end
            n_cmp++; if (tx_cnt !== 32'd2) begin n_bad++; $display("FAIL err_tx_cnt: got %0d want 2", tx_cnt); end
            n_cmp++; if (falls - fb != 1) begin n_bad++; $display("FAIL err_busy_falls: got %0d want 1", falls - fb); end
        end
    endtask

    task automatic test_zero_buf();
        int bb = burst_adr.size(); int fb = falls; int cb = busy_cycles;
        start_xfer(32'h7000, 32'd0, 32'd4);
        wait_done(fb);
        n_cmp++; if (busy_cycles - cb != 1) begin n_bad++; $display("FAIL zero_busy_cycles: got %0d want 1", busy_cycles - cb); end
        n_cmp++; if (burst_adr.size() - bb != 0) begin n_bad++; $display("FAIL zero_bursts: got %0d want 0", burst_adr.size() - bb); end
        n_cmp++; if (tx_cnt !== 32'd0) begin n_bad++; $display("FAIL zero_tx_cnt: got %0d want 0", tx_cnt); end
    endtask

    task automatic test_single_beat();
        int wb = wr_d.size(); int bb = burst_adr.size(); int fb = falls;
        start_xfer(32'h500, 32'd3, 32'd0);
        wait_done(fb);
        n_cmp++; if (burst_adr.size() - bb != 3) begin n_bad++; $display("FAIL single_bursts: got %0d want 3", burst_adr.size() - bb); end
        n_cmp++; if (wr_d.size() - wb != 3) begin n_bad++; $display("FAIL single_count: got %0d want 3", wr_d.size() - wb); end
        for (int i = 0; i < 3; i++) if (wb + i < wr_d.size()) begin
            n_cmp++; if (wr_cti[wb+i] !== 3'b111) begin n_bad++; $display("FAIL single_cti[%0d]: got %b want 111", i, wr_cti[wb+i]); end
        end
    endtask

    task automatic test_addr_wrap();
        int wb = wr_d.size(); int fb = falls;
        logic [31:0] a;
        start_xfer(32'hFFFF_FFFB, 32'd4, 32'd4);
        wait_done(fb);
        n_cmp++; if (wr_d.size() - wb != 4) begin n_bad++; $display("FAIL wrap_count: got %0d want 4", wr_d.size() - wb); end
        for (int i = 0; i < 4; i++) if (wb + i < wr_d.size()) begin
            a = 32'hFFFF_FFF8 + 32'(4*i);
            n_cmp++; if (wr_d[wb+i] !== mem_word(a)) begin n_bad++; $display("FAIL wrap_data[%0d]: got %h want %h", i, wr_d[wb+i], mem_word(a)); end
        end
        n_cmp++; if (wbm_adr_o !== 32'h8) begin n_bad++; $display("FAIL wrap_final_adr: got %h want 8", wbm_adr_o); end
    endtask

    task automatic test_ignored_enable();
        int wb = wr_d.size(); int fb = falls;
        stall_mode = 1'b1;
        start_xfer(32'h2000, 32'd8, 32'd4);
        repeat (3) step();
        start_adr  = 32'h3000;
        buf_size   = 32'd2;
        burst_size = 32'd1;
        enable     = 1'b1;
        step();
        enable     = 1'b0;
        wait_done(fb);
        stall_mode = 1'b0;
        repeat (4) step();
        n_cmp++; if (wr_d.size() - wb != 8) begin n_bad++; $display("FAIL ign_count: got %0d want 8", wr_d.size() - wb); end
        for (int i = 0; i < 8; i++) if (wb + i < wr_d.size()) begin
            n_cmp++; if (wr_d[wb+i] !== mem_word(32'h2000 + 32'(4*i))) begin n_bad++; $display("FAIL ign_data[%0d]: got %h want %h", i, wr_d[wb+i], mem_word(32'h2000 + 32'(4*i))); end
        end
        n_cmp++; if (tx_cnt !== 32'd8) begin n_bad++; $display("FAIL ign_tx_cnt: got %0d want 8", tx_cnt); end
        n_cmp++; if (falls - fb != 1 || busy !== 1'b0) begin n_bad++; $display("FAIL ign_busy: got falls=%0d busy=%b want 1 0", falls - fb, busy); end
    endtask

    task automatic test_reset_mid_burst();
        int k = 0;
        start_xfer(32'h8000, 32'd8, 32'd4);
        while (wbm_cyc_o !== 1'b1 && k < 20) begin step(); k++; end
        if (wbm_cyc_o !== 1'b1) begin
            n_cmp++; n_bad++; $display("FAIL rst_no_cyc: got cyc=%b want 1", wbm_cyc_o);
        end else begin
            step();
            wb_rst_i = 1'b1;
            step();
            n_cmp++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin n_bad++; $display("FAIL rst_cyc: got cyc=%b stb=%b want 0 0", wbm_cyc_o, wbm_stb_o); end
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
            n_cmp++; if (tx_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_tx_cnt: got %0d want 0", tx_cnt); end
            wb_rst_i = 1'b0;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_final();
        test_clamp();
        test_backpressure();
        test_bus_error();
        test_zero_buf();
        test_single_beat();
        test_addr_wrap();
        test_ignored_enable();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_stream_reader_ctrl.md
Name: wb_stream_reader_ctrl

Overview:
Wishbone burst-read master sitting between the stream reader config registers and the stream output FIFO. On an enable pulse it reads buf_size words from memory, starting at start_adr, in incrementing bursts of up to burst_size words. Each returned word is pushed into the downstream FIFO write port. It reports busy and a live word count back to the config block; the config block raises its irq on the falling edge of busy.

Parameters:
WB_AW, 32, Wishbone address width; also the width of start_adr, buf_size and burst_size.
WB_DW, 32, Wishbone data width; also the width of fifo_d and tx_cnt.
FIFO_AW, 0, log2 of the downstream FIFO depth; FIFO depth = 2**FIFO_AW words.
MAX_BURST_LEN, 32, cap on beats per burst; burst_size values above this are clamped.

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  synchronous active-high reset
wbm_adr_o  out  WB_AW  byte address
wbm_dat_o  out  WB_DW  tied to 0
wbm_sel_o  out  WB_DW/8  tied to all ones
wbm_we_o  out  1  tied to 0
wbm_cyc_o  out  1  bus cycle
wbm_stb_o  out  1  strobe
wbm_cti_o  out  3  3'b010 incrementing burst, 3'b111 on the last beat
wbm_bte_o  out  2  tied to 2'b00 (linear)
wbm_dat_i  in  WB_DW  read data
wbm_ack_i  in  1  beat acknowledge
wbm_err_i  in  1  bus error
fifo_d  out  WB_DW  word to FIFO
fifo_wr  out  1  FIFO write strobe
fifo_cnt  in  FIFO_AW+1  current FIFO fill level in words
enable  in  1  single-cycle start pulse
start_adr  in  WB_AW  byte start address; bits [1:0] ignored
buf_size  in  WB_AW  transfer length in words
burst_size  in  WB_AW  words per burst
busy  out  1  transfer in progress
tx_cnt  out  WB_DW  words transferred so far in the current buffer

Behaviour:
- Reset values: cyc, stb, fifo_wr and busy = 0; tx_cnt = 0; wbm_adr_o = 0; wbm_cti_o = 3'b000; FSM in IDLE.
- Reset mid-burst drops cyc/stb in the same clock edge, with no bus termination.
- Registers latched at start: address counter from start_adr with [1:0] forced to 0, remaining = buf_size, effective burst length blen.
- blen = burst_size clamped to [1, MAX_BURST_LEN]; burst_size = 0 is treated as 1.
- FSM states: IDLE, WAIT_SPACE, BURST, DONE.
- IDLE:
  - enable=1 with buf_size != 0 -> WAIT_SPACE; busy=1, tx_cnt=0.
  - enable=1 with buf_size = 0 -> DONE; busy is high exactly one cycle so the config block still sees a falling edge.
- WAIT_SPACE:
  - Computes beats = min(blen, remaining) and free = 2**FIFO_AW - fifo_cnt.
  - When free >= beats -> BURST: cyc=stb=1, beat counter = beats.
  - Until then the block stalls with no bus activity.
- BURST:
  - Each cycle with wbm_ack_i=1: fifo_wr=1 and fifo_d=wbm_dat_i in the same cycle (fifo_wr is combinational from ack), address += WB_DW/8, tx_cnt += 1, remaining -= 1, beat counter -= 1.
  - wbm_cti_o = 3'b111 while the beat counter is 1, otherwise 3'b010; a single-beat burst uses 3'b111.
  - After the final beat's ack, cyc/stb go low on the next cycle. Then remaining = 0 -> DONE, otherwise -> WAIT_SPACE.
  - Cycles with stb high and no ack are wait states; outputs hold.
- wbm_err_i=1 in BURST: no FIFO write for that beat; cyc/stb drop next cycle; -> DONE. tx_cnt holds the count of words delivered before the error.
- DONE: busy=0 next cycle -> IDLE. tx_cnt holds its final value until the next start.
- enable is ignored in every state except IDLE.
- Address counter wraps modulo 2**WB_AW with no error.
- tx_cnt is combinationally valid; the config block scales it to bytes.

Decomposition:
- Shared package: CTI constants (CTI_CLASSIC=3'b000, CTI_INC_BURST=3'b010, CTI_END=3'b111), BTE_LINEAR=2'b00, FSM state encoding.
- The burst-length/free-space computation (min, clamp, compare) goes in one sub-module, wb_stream_burst_calc: purely combinational, reusable by the writer-side controller.

Test Plan:
- Basic transfer: start_adr=0x1000, buf_size=8, burst_size=4, FIFO_AW=4, fifo_cnt=0, ack every cycle -> two bursts at 0x1000 and 0x1010; 8 fifo_wr pulses in address order; cti pattern 010,010,010,111 per burst; tx_cnt=8; busy falls once.
- Short final burst: buf_size=10, burst_size=4 -> bursts of 4, 4, 2; the last burst's cti is 010,111; final address 0x1028.
- Backpressure: FIFO_AW=3, fifo_cnt=6, burst_size=4 -> no cyc until fifo_cnt<=4; then the burst proceeds.
- Bus error: err on beat 3 of the first burst -> cyc low the next cycle; 2 fifo_wr pulses; tx_cnt=2; busy falls.
- Degenerate: buf_size=0 -> busy high exactly one cycle, no cyc. burst_size=0 -> single-beat bursts with cti=111.
- Reset mid-burst and ignored enable: wb_rst_i asserted during beat 2 -> cyc, busy and tx_cnt all 0 at the next edge. enable pulsed while busy -> transfer unaffected.
